// File: rtl/pe_types.sv
// rtl/pe_types.sv - shared packet type for mesh/smem lane endpoints
package pe_types;

    localparam int PACKET_W = 32;

    typedef logic [PACKET_W-1:0] packet_t;

endpackage

// File: rtl/pe_sa_fifo.sv
// rtl/pe_sa_fifo.sv - show-ahead FIFO with registered occupancy and reject pulses
module pe_sa_fifo
    import pe_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  packet_t i_wdata,
    output logic    o_full,
    input  logic    i_pop,
    output packet_t o_rdata,
    output logic    o_empty,
    output logic    o_push_rej,
    output logic    o_pop_rej
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    packet_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == '0);
    // Rejects are judged on the status at the start of the cycle, so a pop
    // never frees room for a same-cycle push and a push never feeds a pop.
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_push_rej = i_push && o_full;
    assign o_pop_rej  = i_pop && o_empty;
    assign o_rdata    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ONE_PTR;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ONE_PTR;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_link_endpoint.sv
// rtl/pe_link_endpoint.sv - host-side endpoint for one mesh/smem edge link lane
module pe_link_endpoint
    import pe_types::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_tx_push,
    input  packet_t          host_tx_wdata,
    output logic             host_tx_full,
    input  logic             link_tx_deq,
    output logic             link_tx_empty,
    output packet_t          link_tx_rdata,
    output logic             link_rx_deq,
    input  logic             link_rx_empty,
    input  packet_t          link_rx_rdata,
    input  logic             host_rx_pop,
    output logic             host_rx_empty,
    output packet_t          host_rx_rdata,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count,
    output logic             err_tx_ovf,
    output logic             err_rx_udf
);

    logic w_tx_full;
    logic w_tx_empty;
    logic w_tx_push_rej;
    logic w_tx_pop_rej;
    logic w_rx_full;
    logic w_rx_empty;
    logic w_rx_push_rej;
    logic w_rx_pop_rej;
    logic w_tx_xfer;
    logic w_rx_xfer;
    logic w_unused_rej;

    logic [CNT_W-1:0] r_tx_count;
    logic [CNT_W-1:0] r_rx_count;
    logic             r_err_tx_ovf;
    logic             r_err_rx_udf;

    // A mesh pop while nothing is offered is a legal no-op, and the RX push is
    // already gated by !full, so neither of these rejects is an error.
    assign w_unused_rej = w_tx_pop_rej | w_rx_push_rej;

    assign w_tx_xfer = link_tx_deq && !w_tx_empty;
    assign w_rx_xfer = !link_rx_empty && !w_rx_full;

    pe_sa_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (host_tx_push),
        .i_wdata    (host_tx_wdata),
        .o_full     (w_tx_full),
        .i_pop      (link_tx_deq),
        .o_rdata    (link_tx_rdata),
        .o_empty    (w_tx_empty),
        .o_push_rej (w_tx_push_rej),
        .o_pop_rej  (w_tx_pop_rej)
    );

    pe_sa_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rx_xfer),
        .i_wdata    (link_rx_rdata),
        .o_full     (w_rx_full),
        .i_pop      (host_rx_pop),
        .o_rdata    (host_rx_rdata),
        .o_empty    (w_rx_empty),
        .o_push_rej (w_rx_push_rej),
        .o_pop_rej  (w_rx_pop_rej)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_err_tx_ovf <= 1'b0;
            r_err_rx_udf <= 1'b0;
        end else begin
            if (w_tx_xfer) begin
                r_tx_count <= r_tx_count + CNT_W'(1);
            end
            if (w_rx_xfer) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            r_err_tx_ovf <= r_err_tx_ovf | w_tx_push_rej;
            r_err_rx_udf <= r_err_rx_udf | w_rx_pop_rej;
        end
    end

    assign host_tx_full  = w_tx_full;
    assign link_tx_empty = w_tx_empty;
    assign link_rx_deq   = !w_rx_full;
    assign host_rx_empty = w_rx_empty;
    assign tx_count      = r_tx_count;
    assign rx_count      = r_rx_count;
    assign err_tx_ovf    = r_err_tx_ovf;
    assign err_rx_udf    = r_err_rx_udf;

endmodule

// File: tb/tb_pe_link_endpoint.sv
// tb/tb_pe_link_endpoint.sv - scoreboard bench for pe_link_endpoint
module tb_pe_link_endpoint;
    import pe_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_tx_push;
    packet_t     host_tx_wdata;
    logic        host_tx_full;
    logic        link_tx_deq;
    logic        link_tx_empty;
    packet_t     link_tx_rdata;
    logic        link_rx_deq;
    logic        link_rx_empty;
    packet_t     link_rx_rdata;
    logic        host_rx_pop;
    logic        host_rx_empty;
    packet_t     host_rx_rdata;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic        err_tx_ovf;
    logic        err_rx_udf;

    int checks   = 0;
    int failures = 0;
    packet_t exp_tx[$];
    packet_t exp_rx[$];

    always #5 clk = ~clk;

    pe_link_endpoint #(
        .TX_DEPTH (4),
        .RX_DEPTH (4),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_tx_push  (host_tx_push),
        .host_tx_wdata (host_tx_wdata),
        .host_tx_full  (host_tx_full),
        .link_tx_deq   (link_tx_deq),
        .link_tx_empty (link_tx_empty),
        .link_tx_rdata (link_tx_rdata),
        .link_rx_deq   (link_rx_deq),
        .link_rx_empty (link_rx_empty),
        .link_rx_rdata (link_rx_rdata),
        .host_rx_pop   (host_rx_pop),
        .host_rx_empty (host_rx_empty),
        .host_rx_rdata (host_rx_rdata),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .err_tx_ovf    (err_tx_ovf),
        .err_rx_udf    (err_rx_udf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_tx_full"},  32'(host_tx_full),  32'd0);
        chk({tag, "_tx_empty"}, 32'(link_tx_empty), 32'd1);
        chk({tag, "_tx_rdata"}, link_tx_rdata,      32'd0);
        chk({tag, "_rx_deq"},   32'(link_rx_deq),   32'd1);
        chk({tag, "_rx_empty"}, 32'(host_rx_empty), 32'd1);
        chk({tag, "_rx_rdata"}, host_rx_rdata,      32'd0);
        chk({tag, "_tx_count"}, 32'(tx_count),      32'd0);
        chk({tag, "_rx_count"}, 32'(rx_count),      32'd0);
        chk({tag, "_err_ovf"},  32'(err_tx_ovf),    32'd0);
        chk({tag, "_err_udf"},  32'(err_rx_udf),    32'd0);
    endtask

    // Monitor: every link/host transfer is compared against the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (link_tx_deq && !link_tx_empty) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h expected=none", link_tx_rdata);
                end else begin
                    chk("tx_data", link_tx_rdata, exp_tx.pop_front());
                end
            end
            if (host_rx_pop && !host_rx_empty) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=%0h expected=none", host_rx_rdata);
                end else begin
                    chk("rx_data", host_rx_rdata, exp_rx.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        logic acc;

        rst           = 1'b1;
        host_tx_push  = 1'b0;
        host_tx_wdata = '0;
        link_tx_deq   = 1'b0;
        link_rx_empty = 1'b1;
        link_rx_rdata = '0;
        host_rx_pop   = 1'b0;
        step();
        step();
        chk_reset_state("rst0");
        rst = 1'b0;
        step();

        // Fill TX with 1..4, no consumer; fifth push must be dropped.
        for (int i = 1; i <= 4; i++) begin
            host_tx_push  = 1'b1;
            host_tx_wdata = packet_t'(i);
            exp_tx.push_back(packet_t'(i));
            if (i == 1) begin
                chk("tx_empty_before_push", 32'(link_tx_empty), 32'd1);
            end
            step();
            if (i == 1) begin
                chk("tx_empty_1cyc_latency", 32'(link_tx_empty), 32'd0);
            end
        end
        host_tx_push = 1'b0;
        chk("tx_full_after4", 32'(host_tx_full), 32'd1);
        chk("tx_head_is_1", link_tx_rdata, 32'd1);
        chk("ovf_clear_before", 32'(err_tx_ovf), 32'd0);
        host_tx_push  = 1'b1;
        host_tx_wdata = packet_t'(5);
        step();
        host_tx_push = 1'b0;
        chk("ovf_set", 32'(err_tx_ovf), 32'd1);
        chk("tx_full_still", 32'(host_tx_full), 32'd1);

        // Drain: 1,2,3,4 one per cycle.
        link_tx_deq = 1'b1;
        for (n = 0; n < 10 && !link_tx_empty; n++) begin
            step();
        end
        chk("tx_drain_cycles", 32'(n), 32'd4);
        chk("tx_empty_after_drain", 32'(link_tx_empty), 32'd1);
        chk("tx_count_4", 32'(tx_count), 32'd4);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);

        // RX: mesh publishes A,B,C,... continuously, host does not pop.
        link_rx_rdata = packet_t'(32'hA);
        link_rx_empty = 1'b0;
        n = 0;
        repeat (8) begin
            acc = link_rx_deq;
            if (acc) begin
                exp_rx.push_back(link_rx_rdata);
            end
            step();
            if (acc) begin
                link_rx_rdata = link_rx_rdata + 32'd1;
                n++;
            end
        end
        link_rx_empty = 1'b1;
        chk("rx_accepted", 32'(n), 32'd4);
        chk("rx_deq_low_full", 32'(link_rx_deq), 32'd0);
        chk("rx_count_4", 32'(rx_count), 32'd4);
        chk("rx_head_A", host_rx_rdata, 32'hA);

        host_rx_pop = 1'b1;
        repeat (4) step();
        host_rx_pop = 1'b0;
        chk("rx_empty_after_pops", 32'(host_rx_empty), 32'd1);
        chk("rx_deq_high_again", 32'(link_rx_deq), 32'd1);
        chk("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        chk("udf_clear_before", 32'(err_rx_udf), 32'd0);

        // Pop on empty RX.
        host_rx_pop = 1'b1;
        step();
        host_rx_pop = 1'b0;
        chk("udf_set", 32'(err_rx_udf), 32'd1);
        chk("rx_count_unchanged", 32'(rx_count), 32'd4);
        repeat (3) step();
        chk("udf_sticky", 32'(err_rx_udf), 32'd1);

        // Steady stream: one packet per cycle, occupancy stays at 1.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            host_tx_push  = 1'b1;
            host_tx_wdata = packet_t'(1000 + i);
            exp_tx.push_back(packet_t'(1000 + i));
            step();
            if (link_tx_empty || host_tx_full) n++;
        end
        host_tx_push = 1'b0;
        chk("stream_occupancy_bad_cycles", 32'(n), 32'd0);
        step();
        chk("stream_tx_empty", 32'(link_tx_empty), 32'd1);
        chk("tx_count_104", 32'(tx_count), 32'd104);

        // Run tx_count up to its maximum, then wrap.
        for (int i = 0; i < 65431; i++) begin
            host_tx_push  = 1'b1;
            host_tx_wdata = packet_t'(i);
            exp_tx.push_back(packet_t'(i));
            step();
        end
        host_tx_push = 1'b0;
        step();
        chk("tx_count_max", 32'(tx_count), 32'h0000FFFF);
        host_tx_push  = 1'b1;
        host_tx_wdata = packet_t'(32'hBEEF);
        exp_tx.push_back(packet_t'(32'hBEEF));
        step();
        host_tx_push = 1'b0;
        step();
        chk("tx_count_wrap", 32'(tx_count), 32'd0);
        chk("tx_queue_drained_2", 32'(exp_tx.size()), 32'd0);

        // Reset with packets buffered in both halves.
        link_tx_deq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            host_tx_push  = 1'b1;
            host_tx_wdata = packet_t'(32'h70 + i);
            step();
        end
        host_tx_push  = 1'b0;
        link_rx_empty = 1'b0;
        link_rx_rdata = packet_t'(32'h55);
        step();
        link_rx_empty = 1'b1;
        chk("pre_rst_tx_busy", 32'(link_tx_empty), 32'd0);
        chk("pre_rst_rx_busy", 32'(host_rx_empty), 32'd0);
        rst = 1'b1;
        step();
        exp_tx.delete();
        exp_rx.delete();
        chk_reset_state("rst1");
        rst = 1'b0;
        link_tx_deq = 1'b1;
        step();
        chk("post_rst_tx_empty", 32'(link_tx_empty), 32'd1);
        chk("post_rst_tx_count", 32'(tx_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
